// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - program counter with conditional branch, call/return stack and address mux
module pc_branch_unit #(
    parameter int AW          = 8,
    parameter int DW          = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          loadpc,
    input  logic          msel,
    input  logic [1:0]    bmode,
    input  logic [2:0]    cond,
    input  logic [2:0]    status,
    input  logic [DW-1:0] sximm8,
    input  logic [DW-1:0] C,
    input  logic          clr_err,
    output logic [AW-1:0] address,
    output logic [AW-1:0] pc,
    output logic          taken,
    output logic          stack_full,
    output logic          stack_empty,
    output logic          stack_err
);
    localparam int CW = $clog2(STACK_DEPTH + 1);

    logic [AW-1:0] pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [AW-1:0] stk_q [STACK_DEPTH];
    logic [AW-1:0] stk_d [STACK_DEPTH];

    logic [AW-1:0] seq, target, top;
    logic          cond_ok, full, empty;

    assign seq    = pc_q + AW'(1);
    assign target = seq + sximm8[AW-1:0];
    assign full   = (cnt_q == CW'(STACK_DEPTH));
    assign empty  = (cnt_q == '0);

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            3'b000:  cond_ok = 1'b1;
            3'b001:  cond_ok = status[0];
            3'b010:  cond_ok = ~status[0];
            3'b011:  cond_ok = status[1] ^ status[2];
            3'b100:  cond_ok = (status[1] ^ status[2]) | status[0];
            default: cond_ok = 1'b0;
        endcase
    end

    // Top of stack is the entry just below the count.
    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (CW'(i + 1) == cnt_q) top = stk_q[i];
        end
    end

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        stk_d = stk_q;
        err_d = err_q & ~clr_err;
        if (loadpc) begin
            pc_d = seq;
            case (bmode)
                2'b01: if (cond_ok) pc_d = target;
                2'b10: if (cond_ok) begin
                    if (full) begin
                        err_d = 1'b1;
                    end else begin
                        for (int i = 0; i < STACK_DEPTH; i++) begin
                            if (CW'(i) == cnt_q) stk_d[i] = seq;
                        end
                        cnt_d = cnt_q + CW'(1);
                        pc_d  = target;
                    end
                end
                2'b11: if (cond_ok) begin
                    if (empty) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                        pc_d  = top;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            stk_q <= stk_d;
        end
    end

    assign taken       = (bmode != 2'b00) & cond_ok & ~((bmode == 2'b10) & full)
                       & ~((bmode == 2'b11) & empty);
    assign address     = msel ? C[AW-1:0] : pc_q;
    assign pc          = pc_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign stack_err   = err_q;
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb/tb_pc_branch_unit.sv - directed self-checking bench for pc_branch_unit
module tb_pc_branch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        loadpc, msel, clr_err;
    logic [1:0]  bmode;
    logic [2:0]  cond, status;
    logic [15:0] sximm8, C;
    logic [7:0]  address, pc;
    logic        taken, stack_full, stack_empty, stack_err;

    int tests = 0;
    int fails = 0;

    pc_branch_unit #(.AW(8), .DW(16), .STACK_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .loadpc(loadpc), .msel(msel), .bmode(bmode),
        .cond(cond), .status(status), .sximm8(sximm8), .C(C), .clr_err(clr_err),
        .address(address), .pc(pc), .taken(taken), .stack_full(stack_full),
        .stack_empty(stack_empty), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; loadpc = 1'b0; msel = 1'b0; clr_err = 1'b0;
        bmode = 2'b00; cond = 3'b000; status = 3'b000; sximm8 = '0; C = '0;
        #12;
        chk("rst_pc", pc, 0);
        chk("rst_addr", address, 0);
        chk("rst_empty", stack_empty, 1);
        chk("rst_full", stack_full, 0);
        chk("rst_err", stack_err, 0);
        chk("inc_taken", taken, 0);
        reset = 1'b1;

        loadpc = 1'b1;
        tick(); chk("inc1", pc, 1);
        tick(); chk("inc2", pc, 2);
        tick(); chk("inc3", pc, 3);
        chk("inc3_addr", address, 3);
        for (int i = 0; i < 252; i++) tick();
        chk("pc255", pc, 255);
        tick(); chk("wrap", pc, 0);
        for (int i = 0; i < 10; i++) tick();
        chk("pc10", pc, 10);

        bmode = 2'b01; cond = 3'b001; sximm8 = 16'hFFFB; status = 3'b001;
        #1 chk("beq_taken", taken, 1);
        tick(); chk("beq_pc", pc, 6);
        bmode = 2'b00;
        for (int i = 0; i < 4; i++) tick();
        bmode = 2'b01; status = 3'b000;
        #1 chk("beq_nt", taken, 0);
        tick(); chk("beq_nt_pc", pc, 11);

        cond = 3'b011; status = 3'b100;
        #1 chk("lt_v", taken, 1);
        cond = 3'b100; status = 3'b000;
        #1 chk("le_f", taken, 0);
        status = 3'b001;
        #1 chk("le_z", taken, 1);
        cond = 3'b101;
        #1 chk("never", taken, 0);

        bmode = 2'b00; cond = 3'b000; status = 3'b000;
        for (int i = 0; i < 9; i++) tick();
        chk("pc20", pc, 20);
        bmode = 2'b10; sximm8 = 16'd30;
        #1 chk("call_taken", taken, 1);
        tick(); chk("call_pc", pc, 51);
        chk("call_nempty", stack_empty, 0);
        bmode = 2'b11;
        #1 chk("ret_taken", taken, 1);
        tick(); chk("ret_pc", pc, 21);
        chk("ret_empty", stack_empty, 1);

        bmode = 2'b10; sximm8 = 16'd0;
        for (int i = 0; i < 4; i++) tick();
        chk("full_pc", pc, 25);
        chk("full", stack_full, 1);
        #1 chk("ovf_taken", taken, 0);
        tick(); chk("ovf_pc", pc, 26);
        chk("ovf_err", stack_err, 1);
        chk("ovf_full", stack_full, 1);
        loadpc = 1'b0; clr_err = 1'b1;
        tick(); chk("clr_err", stack_err, 0);
        chk("hold_pc", pc, 26);
        clr_err = 1'b0; loadpc = 1'b1; bmode = 2'b11;
        tick(); chk("pop1", pc, 25);
        tick(); chk("pop2", pc, 24);
        tick(); chk("pop3", pc, 23);
        tick(); chk("pop4", pc, 22);
        chk("pop_empty", stack_empty, 1);

        #1 chk("unf_taken", taken, 0);
        tick(); chk("unf_pc", pc, 23);
        chk("unf_err", stack_err, 1);
        clr_err = 1'b1;
        tick(); chk("unf_clr_pc", pc, 24);
        chk("err_wins", stack_err, 1);
        loadpc = 1'b0;
        tick(); chk("noload_clr", stack_err, 0);
        chk("noload_pc", pc, 24);
        clr_err = 1'b0;
        tick(); chk("noload_noerr", stack_err, 0);

        msel = 1'b1; C = 16'h12AB;
        tick(); chk("msel_addr", address, 8'hAB);
        chk("msel_pc", pc, 24);
        msel = 1'b0;
        #1 chk("msel0_addr", address, 24);

        loadpc = 1'b1; bmode = 2'b10; cond = 3'b000; sximm8 = 16'd5;
        tick(); chk("call2_pc", pc, 30);
        #2 reset = 1'b0;
        #1;
        chk("arst_pc", pc, 0);
        chk("arst_empty", stack_empty, 1);
        chk("arst_addr", address, 0);
        reset = 1'b1; loadpc = 1'b0;
        tick(); chk("arst_hold", pc, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
